reg_dump_unit: RTL and testbench
================================

// Module: reg_dump_unit
// PURPOSE
//  Read-side debug engine for the mips32 register file. On a start pulse it walks
//  register addresses FIRST..LAST on the register file's rs read port, captures
//  rsData, and streams (address, data) pairs out over a valid/ready handshake.
//  It sits beside registerFile, opposite mips32TOP's brWrite/brAddr/brDataIn write
//  port, and replaces per-register bench polling with one self-timed dump.
// PARAMETERS
//  FIRST_REG  0   first register address dumped (0..31)
//  LAST_REG   31  last register address dumped (FIRST_REG..31); FIRST_REG>LAST_REG is an elaboration error
// PORTS
//  clk        in   1   system clock, all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   1-cycle request to begin a dump; honoured only in IDLE
//  abort      in   1   cancel an in-progress dump
//  rs         out  5   register-file read address (to registerFile.rs)
//  rsData     in   32  register-file read data (combinational from rs)
//  dumpValid  out  1   dumpAddr/dumpData hold a valid word
//  dumpReady  in   1   consumer accepts the word when dumpValid & dumpReady
//  dumpAddr   out  5   register address of the presented word
//  dumpData   out  32  register contents of the presented word
//  busy       out  1   high from the cycle after start is accepted until done
//  done       out  1   1-cycle pulse after the last word is accepted
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, rs=FIRST_REG, dumpValid=0, dumpAddr=0,
//    dumpData=0, busy=0, done=0.
//  - States: IDLE, READ, SEND, DONE. rs is registered, never combinational.
//  - IDLE: start=1 at edge -> READ, rs<=FIRST_REG, busy<=1.
//  - READ (1 cycle): rs stable; at edge dumpData<=rsData, dumpAddr<=rs, dumpValid<=1 -> SEND.
//  - SEND: dumpValid, dumpAddr, dumpData held stable until handshake (valid&ready at edge).
//    On handshake: dumpValid<=0; if rs==LAST_REG -> DONE, else rs<=rs+1 -> READ.
//  - DONE (1 cycle): done=1, busy falls with done's rising edge clock; -> IDLE, rs<=FIRST_REG.
//  - Throughput with dumpReady held high: 2 cycles/word; full 32-reg dump: start edge
//    + 64 cycles + 1 done cycle. dumpValid never asserts in IDLE or DONE.
//  - Address arithmetic is 5-bit; LAST_REG=31 terminates by compare before +1, so rs never wraps.
//  - start while busy or in DONE: ignored, no effect on the dump in progress.
//  - abort in READ or SEND: next edge -> IDLE, dumpValid<=0, busy<=0, done NOT pulsed;
//    abort wins over a simultaneous handshake. abort in IDLE/DONE: no effect.
//  - start and abort together in IDLE: start honoured (abort ignored in IDLE).
//  - Data is sampled at the READ edge; register-file writes landing after that edge do
//    not alter the presented word (snapshot per word, not per dump).
//  - Reset mid-dump: outputs return to reset values asynchronously; no done pulse.
// STRUCTURE
//  - mips32_pkg: REG_ADDR_W=5, DATA_W=32, dump-state enum (IDLE/READ/SEND/DONE).
//  - Single flat module: one FSM plus address register and output holding registers;
//    no sub-module is warranted.
// TESTING
//  1 Reset: assert rst mid-simulation, async -> dumpValid=0, busy=0, done=0, rs=FIRST_REG
//    before next clk edge.
//  2 Program addi $t0,2 / addi $t1,3 / add $t2 run on mips32TOP; FIRST=8, LAST=10,
//    ready=1, start -> words (8,2),(9,3),(10,5) on consecutive 2-cycle slots, done 1 cycle later.
//  3 Backpressure: ready=0 for 5 cycles while valid on reg 9 -> addr/data stable
//    (9,3), no advance; ready=1 -> accepted, reg 10 presented 2 cycles after.
//  4 Full dump FIRST=0, LAST=31 after reset: 32 words, reg 0 = 0, rs never wraps,
//    done exactly 65 cycles after start edge.
//  5 start pulsed during SEND of reg 9 -> ignored; sequence and done timing unchanged.
//  6 abort asserted with simultaneous handshake on reg 9 -> IDLE, no done, busy=0;
//    new start then dumps from FIRST_REG again.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared widths and the register-dump FSM state encoding for the mips32 debug path.
package mips32_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;
endpackage

// File: rtl/reg_dump_unit.sv
// Walks register addresses FIRST_REG..LAST_REG on the register file's rs port and
// streams (address, data) snapshots out over a valid/ready handshake.
module reg_dump_unit
  import mips32_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0]     rsData,
  output logic                  dumpValid,
  input  logic                  dumpReady,
  output logic [REG_ADDR_W-1:0] dumpAddr,
  output logic [DATA_W-1:0]     dumpData,
  output logic                  busy,
  output logic                  done
);
  localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

  if (FIRST_REG < 0 || LAST_REG > 31 || FIRST_REG > LAST_REG) begin : g_bad_range
    $error("reg_dump_unit: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  dump_state_e state, state_nxt;
  logic        capture, advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // abort outranks the handshake; the last word ends by compare so rs never wraps
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        if (abort) state_nxt = IDLE;
        else begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (abort) state_nxt = IDLE;
        else if (dumpValid && dumpReady) begin
          if (rs == LAST_A) state_nxt = DONE;
          else begin
            advance   = 1'b1;
            state_nxt = READ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs        <= FIRST_A;
      dumpValid <= 1'b0;
      dumpAddr  <= '0;
      dumpData  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      dumpValid <= (state_nxt == SEND);
      busy      <= (state_nxt == READ) || (state_nxt == SEND);
      done      <= (state_nxt == DONE);
      if (capture) begin
        dumpAddr <= rs;
        dumpData <= rsData;
      end
      if (advance)                                  rs <= rs + 1'b1;
      else if (state == IDLE || state_nxt == IDLE) rs <= FIRST_A;
    end
  end
endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: two instances (regs 8..10 and 0..31) checked every cycle
// against a transaction-level model, plus hand-computed timing/data expectations.
module tb_reg_dump_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  start = '0, abort = '0, ready = '0;
  logic [4:0]  rs [2];
  logic [4:0]  daddr [2];
  logic [31:0] rsd [2];
  logic [31:0] ddata [2];
  logic        dvalid [2];
  logic        busy [2];
  logic        done [2];
  logic [31:0] mem [32];

  always_comb begin
    rsd[0] = mem[rs[0]];
    rsd[1] = mem[rs[1]];
  end

  reg_dump_unit #(.FIRST_REG(8), .LAST_REG(10)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .rs(rs[0]), .rsData(rsd[0]),
    .dumpValid(dvalid[0]), .dumpReady(ready[0]), .dumpAddr(daddr[0]), .dumpData(ddata[0]),
    .busy(busy[0]), .done(done[0]));

  reg_dump_unit #(.FIRST_REG(0), .LAST_REG(31)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .rs(rs[1]), .rsData(rsd[1]),
    .dumpValid(dvalid[1]), .dumpReady(ready[1]), .dumpAddr(daddr[1]), .dumpData(ddata[1]),
    .busy(busy[1]), .done(done[1]));

  int total = 0, bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: a dump is a list of words FIRST..LAST; each word needs one
  // read cycle then waits for acceptance; data is whatever the register held at read time.
  int          fst [2] = '{8, 0};
  int          lst [2] = '{10, 31};
  bit          m_act [2], m_v [2], m_w [2], m_d [2];
  int          m_a [2];
  logic [31:0] m_dat [2];
  bit          dn;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_v[i] = 0; m_w[i] = 0; m_d[i] = 0; m_a[i] = fst[i];
      end else begin
        dn = 0;
        if (m_act[i] && abort[i]) begin
          m_act[i] = 0; m_v[i] = 0; m_w[i] = 0;
        end else if (m_w[i]) begin
          m_w[i] = 0; m_v[i] = 1; m_dat[i] = mem[m_a[i]];
        end else if (m_v[i]) begin
          if (ready[i]) begin
            m_v[i] = 0;
            if (m_a[i] == lst[i]) begin m_act[i] = 0; dn = 1; end
            else begin m_a[i]++; m_w[i] = 1; end
          end
        end else if (!m_act[i] && !m_d[i] && start[i]) begin
          m_act[i] = 1; m_a[i] = fst[i]; m_w[i] = 1;
        end
        m_d[i] = dn;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), 32'(dvalid[i]), 32'(m_v[i]));
      chk($sformatf("busy%0d", i),  32'(busy[i]),   32'(m_act[i]));
      chk($sformatf("done%0d", i),  32'(done[i]),   32'(m_d[i]));
      if (m_act[i]) chk($sformatf("rs%0d", i), 32'(rs[i]), m_a[i]);
      if (m_v[i]) begin
        chk($sformatf("addr%0d", i), 32'(daddr[i]), m_a[i]);
        chk($sformatf("data%0d", i), ddata[i], m_dat[i]);
      end
    end
  end

  // Accepted-word log with edge timestamps for the literal expectations
  typedef struct { int a; logic [31:0] d; int t; } w_t;
  w_t log0 [$], log1 [$];
  int cyc = 0;
  int st [2] = '{0, 0};
  int dt [2] = '{0, 0};
  int dcnt [2] = '{0, 0};

  always @(posedge clk) begin
    if (!rst) begin
      if (dvalid[0] && ready[0] && !abort[0]) log0.push_back('{int'(daddr[0]), ddata[0], cyc});
      if (dvalid[1] && ready[1] && !abort[1]) log1.push_back('{int'(daddr[1]), ddata[1], cyc});
      for (int i = 0; i < 2; i++) begin
        if (start[i] && !busy[i] && !done[i]) st[i] = cyc;
        if (done[i]) begin dt[i] = cyc; dcnt[i]++; end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(int i);
    start[i] = 1'b1; tick(); start[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int lim);
    int n = 0;
    while (!done[i] && n < lim) begin tick(); n++; end
    if (!done[i]) begin
      total++; bad++;
      $display("FAIL wait_done%0d: got no done within %0d cycles, required done", i, lim);
    end
  endtask

  task automatic wait_addr(int i, int a, int lim);
    int n = 0;
    while (!(dvalid[i] && daddr[i] == 5'(a)) && n < lim) begin tick(); n++; end
    if (!(dvalid[i] && daddr[i] == 5'(a))) begin
      total++; bad++;
      $display("FAIL wait_addr%0d: got no word for reg %0d within %0d cycles", i, a, lim);
    end
  endtask

  int b, dc;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h11;
    mem[0] = 32'd0; mem[8] = 32'd2; mem[9] = 32'd3; mem[10] = 32'd5;
    ready = 2'b11;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_rs0", 32'(rs[0]), 8);
    chk("rst_rs1", 32'(rs[1]), 0);

    // basic 8..10 dump: words (8,2),(9,3),(10,5) at 2-cycle slots
    b = log0.size();
    pulse_start(0);
    wait_done(0, 20);
    tick(); tick();
    chk("t2_cnt", log0.size() - b, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_a%0d", k), log0[b+k].a, 8 + k);
      chk($sformatf("t2_t%0d", k), log0[b+k].t - st[0], 2 * (k + 1));
    end
    chk("t2_d0", log0[b].d, 2); chk("t2_d1", log0[b+1].d, 3); chk("t2_d2", log0[b+2].d, 5);
    chk("t2_done_lat", dt[0] - st[0], 7);

    // backpressure on reg 9, with a register write that must not leak into the word
    b = log0.size();
    pulse_start(0);
    wait_addr(0, 9, 20);
    ready[0] = 1'b0;
    mem[9] = 32'hDEAD_BEEF;
    repeat (5) begin
      tick();
      chk("t3_hold_v", 32'(dvalid[0]), 1);
      chk("t3_hold_a", 32'(daddr[0]), 9);
      chk("t3_hold_d", ddata[0], 3);
    end
    ready[0] = 1'b1;
    mem[9] = 32'd3;
    wait_done(0, 20);
    tick(); tick();
    chk("t3_cnt", log0.size() - b, 3);
    chk("t3_gap89", log0[b+1].t - log0[b].t, 7);
    chk("t3_gap910", log0[b+2].t - log0[b+1].t, 2);
    chk("t3_d9", log0[b+1].d, 3);

    // start during SEND and during DONE is ignored
    b = log0.size();
    pulse_start(0);
    wait_addr(0, 9, 20);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    wait_done(0, 20);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (4) tick();
    chk("t5_cnt", log0.size() - b, 3);
    chk("t5_t2", log0[b+2].t - st[0], 6);
    chk("t5_done_lat", dt[0] - st[0], 7);
    chk("t5_busy", 32'(busy[0]), 0);

    // abort with simultaneous handshake on reg 9
    b = log0.size();
    dc = dcnt[0];
    pulse_start(0);
    wait_addr(0, 9, 20);
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    chk("t6_busy", 32'(busy[0]), 0);
    chk("t6_valid", 32'(dvalid[0]), 0);
    repeat (3) tick();
    chk("t6_cnt", log0.size() - b, 1);
    chk("t6_nodone", dcnt[0] - dc, 0);
    // start together with abort in IDLE is honoured
    b = log0.size();
    start[0] = 1'b1; abort[0] = 1'b1; tick(); start[0] = 1'b0; abort[0] = 1'b0;
    wait_done(0, 20);
    tick(); tick();
    chk("t6_re_cnt", log1.size() >= 0 ? log0.size() - b : 0, 3);
    chk("t6_re_a0", log0[b].a, 8);

    // full 0..31 dump after reset
    rst = 1'b1; tick(); rst = 1'b0; tick();
    b = log1.size();
    pulse_start(1);
    wait_done(1, 100);
    tick(); tick();
    chk("t4_cnt", log1.size() - b, 32);
    chk("t4_r0", log1[b].d, 0);
    for (int k = 0; k < 32; k++) chk($sformatf("t4_a%0d", k), log1[b+k].a, k);
    chk("t4_d31", log1[b+31].d, 32'h1000_0000 + 32'd31 * 32'h11);
    chk("t4_done_lat", dt[1] - st[1], 65);

    // asynchronous reset mid-dump
    pulse_start(1);
    repeat (10) tick();
    chk("t1_pre_busy", 32'(busy[1]), 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t1_valid", 32'(dvalid[1]), 0);
    chk("t1_busy", 32'(busy[1]), 0);
    chk("t1_done", 32'(done[1]), 0);
    chk("t1_rs1", 32'(rs[1]), 0);
    chk("t1_rs0", 32'(rs[0]), 8);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
